// File: rtl/seq_gen_1011_if.sv
// Load handshake bundle for seq_gen_1011: a producer hands parallel words to
// the serial transmitter over load_valid/load_ready.
interface seq_gen_1011_if #(
    parameter int unsigned DATA_W = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seq_gen_1011.sv
// Serial frame transmitter: shifts a parallel word out MSB first, one bit per
// enabled clock. Define SEQ_GEN_SYNC_HDR_EN to prefix every frame with 1011.
module seq_gen_1011 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_gen_1011_if.slave        load,
    input  logic                 tx_en,
    output logic                 out_bit,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              out_bit_nxt, out_valid_nxt;
    logic              xfer;

`ifdef SEQ_GEN_SYNC_HDR_EN
    localparam logic [3:0] HDR_PAT = 4'b1011;
    logic [1:0] hdr_cnt, hdr_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEQ_GEN_SYNC_HDR_EN
            hdr_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            out_bit   <= out_bit_nxt;
            out_valid <= out_valid_nxt;
`ifdef SEQ_GEN_SYNC_HDR_EN
            hdr_cnt   <= hdr_nxt;
`endif
        end
    end

    // out_bit is registered, so every branch computes the bit for the next cycle.
    always_comb begin
        state_nxt       = state;
        shreg_nxt       = shreg;
        cnt_nxt         = cnt;
        out_bit_nxt     = out_bit;
        out_valid_nxt   = out_valid;
        load.load_ready = 1'b0;
        frame_done      = 1'b0;
        busy            = (state != IDLE);
`ifdef SEQ_GEN_SYNC_HDR_EN
        hdr_nxt         = hdr_cnt;
`endif

        case (state)
            IDLE: load.load_ready = 1'b1;
`ifdef SEQ_GEN_SYNC_HDR_EN
            HDR: begin
                if (tx_en) begin
                    if (hdr_cnt == 2'd3) begin
                        state_nxt   = DATA;
                        out_bit_nxt = shreg[DATA_W-1];
                    end else begin
                        hdr_nxt     = hdr_cnt + 2'd1;
                        out_bit_nxt = HDR_PAT[~hdr_nxt];
                    end
                end
            end
`endif
            DATA: begin
                if (tx_en) begin
                    shreg_nxt = shreg << 1;
                    cnt_nxt   = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt     = GAP;
                        out_bit_nxt   = 1'b0;
                        out_valid_nxt = 1'b0;
                    end else begin
                        out_bit_nxt = shreg[DATA_W-2];
                    end
                end
            end
            GAP: begin
                load.load_ready = tx_en;
                if (tx_en) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        xfer = load.load_valid && load.load_ready;
        if (xfer) begin
            shreg_nxt     = load.load_data;
            cnt_nxt       = CNT_W'(DATA_W);
            out_valid_nxt = 1'b1;
`ifdef SEQ_GEN_SYNC_HDR_EN
            state_nxt     = HDR;
            hdr_nxt       = '0;
            out_bit_nxt   = HDR_PAT[3];
`else
            state_nxt     = DATA;
            out_bit_nxt   = load.load_data[DATA_W-1];
`endif
        end
    end
endmodule
